caesar_stream_engine: RTL
=========================

Name: caesar_stream_engine

Overview:
- Parametrised successor to the board-level Caesar demo counter.
- Folds into one synchronous block:
  - the 1 Hz pacing;
  - the wrapping plaintext counter;
  - a latched, range-checked key;
  - registered encrypt/decrypt arithmetic.
- Adds run/pause/single-step control, up/down counting, configurable alphabet size and an output-valid strobe.
- Sits between the switch/debounce logic and the binary-to-BCD/7-segment display path.

Parameters:
- CLK_HZ, 50000000, input clock frequency.
- TICK_HZ, 1, advance rate while running. DIV = CLK_HZ/TICK_HZ; DIV must be >= 1.
- ALPHABET, 26, symbol count N. Symbols are 0..N-1; N must be >= 2 and <= 2^WIDTH.
- WIDTH, 6, bit width of symbol and key buses.

Ports:
- CLOCK_50  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- run  in  1  level: 1 = RUNNING, 0 = STOPPED.
- step  in  1  level. A 0->1 edge while STOPPED advances the counter once.
- dir  in  1  0 = count up, 1 = count down. Sampled at each advance.
- encrypt  in  1  1 = cipher_out is encryption, 0 = decryption.
- key_load  in  1  1-cycle strobe: capture key_in.
- key_in  in  WIDTH  candidate key.
- plain_out  out  WIDTH  current counter symbol.
- key_out  out  WIDTH  active key.
- cipher_out  out  WIDTH  registered result.
- out_valid  out  1  1-cycle pulse when cipher_out has been updated.
- tick  out  1  1-cycle prescaler pulse.
- key_err  out  1  sticky: last key_load was out of range.

Behaviour:
- Reset (rst=1 at a clock edge) clears the prescaler and the step-edge register, forces state STOPPED, and drives every output to 0. This takes priority over every other input that cycle.
- FSM, two states:
  - STOPPED -> RUNNING when run=1.
  - RUNNING -> STOPPED when run=0.
  - The transition takes effect on the edge where run is sampled.
  - Entering RUNNING clears the prescaler, so the first tick comes DIV cycles later.
- Prescaler:
  - Counts 0..DIV-1 only in RUNNING and holds at 0 in STOPPED.
  - tick=1 in the cycle where the count equals DIV-1, then the count wraps to 0.
  - DIV=1 gives tick every cycle.
- Advance event:
  - In RUNNING: tick=1.
  - In STOPPED: step=1 while the registered step was 0.
  - step edges are ignored in RUNNING. The edge register still tracks step in RUNNING, so a held step gives no advance after stopping.
- Counter, updated on the edge after the advance event:
  - dir=0: plain = (plain == N-1) ? 0 : plain+1.
  - dir=1: plain = (plain == 0) ? N-1 : plain-1.
- Key:
  - On key_load with key_in < N: key_out <= key_in and key_err <= 0.
  - On key_load with key_in >= N: key_out is unchanged and key_err <= 1.
  - key_err holds until the next valid load or reset.
- Arithmetic, using only compare-and-subtract (no modulo operator). Evaluated on the current registered plain_out, key_out and encrypt. Intermediates are WIDTH+1 bits.
  - enc = (p+k >= N) ? p+k-N : p+k.
  - dec = (p >= k) ? p-k : p+N-k.
- cipher_out registers the selected result every cycle, so it lags plain/key/encrypt changes by exactly 1 cycle.
- out_valid pulses in the cycle cipher_out first reflects any of these, in the preceding cycle:
  - an advance;
  - a key update (valid key_load);
  - a change of encrypt.
- Simultaneous events:
  - An advance and a valid key_load in the same cycle: both are applied, and one out_valid pulse follows.
  - An invalid key_load alone gives no out_valid.
- Reset mid-operation: counter, key and err are cleared immediately, regardless of state or a pending tick.

Test Plan (CLK_HZ=4, TICK_HZ=1, ALPHABET=26, WIDTH=6):
- Reset, then run=1, dir=0, key_load key_in=3, encrypt=1:
  - tick every 4 cycles;
  - plain 0->1->2;
  - cipher_out 3, 4, 5, each 1 cycle after its plain value;
  - out_valid pulses aligned.
- Wrap: plain at 25, key=3, encrypt=1, next tick -> plain=0, cipher=3. Preceding value 25 gives cipher=2 (25+3-26).
- Decrypt/down: dir=1, encrypt=0, key=5, plain=0, tick -> plain=25, cipher=20. For plain=2, cipher=23.
- Key range: key_load key_in=26 -> key_out unchanged, key_err=1, no out_valid. Then key_in=25 -> key_out=25, key_err=0.
- Step mode: run=0, step held high for 10 cycles -> exactly one advance. Any tick while stopped is 0.
- Reset mid-run with plain=17 and key=9 -> next cycle all outputs 0, state STOPPED. run=1 -> first tick 4 cycles later.

Source files
------------

// File: rtl/caesar_stream_engine.sv
// ---------------------------------------------------------------------------
// caesar_stream_engine
//   Paced Caesar-cipher demo engine. A plaintext symbol counter advances on a
//   prescaled tick while RUNNING, or on a single step edge while STOPPED. The
//   active key is latched with a range check, and cipher_out holds the
//   registered encrypt/decrypt result of the current plaintext and key.
//
// Ports
//   CLOCK_50   in   system clock, rising edge
//   rst        in   synchronous reset, active high
//   run        in   1 = RUNNING, 0 = STOPPED
//   step       in   rising edge advances once while STOPPED
//   dir        in   0 = count up, 1 = count down
//   encrypt    in   1 = encrypt, 0 = decrypt
//   key_load   in   strobe: capture key_in
//   key_in     in   candidate key
//   plain_out  out  current plaintext symbol
//   key_out    out  active key
//   cipher_out out  registered cipher result
//   out_valid  out  pulse when cipher_out has been updated
//   tick       out  prescaler pulse
//   key_err    out  sticky flag: last key_load was out of range
// ---------------------------------------------------------------------------
module caesar_stream_engine #(
  parameter int CLK_HZ   = 50000000,
  parameter int TICK_HZ  = 1,
  parameter int ALPHABET = 26,
  parameter int WIDTH    = 6
) (
  input  logic             CLOCK_50,
  input  logic             rst,
  input  logic             run,
  input  logic             step,
  input  logic             dir,
  input  logic             encrypt,
  input  logic             key_load,
  input  logic [WIDTH-1:0] key_in,
  output logic [WIDTH-1:0] plain_out,
  output logic [WIDTH-1:0] key_out,
  output logic [WIDTH-1:0] cipher_out,
  output logic             out_valid,
  output logic             tick,
  output logic             key_err
);

  localparam int               DIV    = CLK_HZ / TICK_HZ;
  localparam int               CNT_W  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] DIV_M1 = CNT_W'(DIV - 1);
  // Alphabet size needs WIDTH+1 bits so that N = 2^WIDTH is representable.
  localparam logic [WIDTH:0]   N_W    = (WIDTH + 1)'(ALPHABET);
  localparam logic [WIDTH-1:0] N_M1   = WIDTH'(ALPHABET - 1);

  typedef enum logic [0:0] {
    ST_STOPPED = 1'b0,
    ST_RUNNING = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;
  logic             step_q, step_d;
  logic [WIDTH-1:0] plain_q, plain_d;
  logic [WIDTH-1:0] key_q, key_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] cipher_q, cipher_d;
  logic             valid_q, valid_d;
  logic             upd_q, upd_d;   // plain or key took a new value at the last edge
  logic             enc_q, enc_d;   // encrypt as seen last cycle, for change detection

  logic             adv_s;
  logic             key_ok_s;
  logic [WIDTH:0]   sum_s;

  // Run/stop state selection.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_STOPPED: begin
        if (run) state_d = ST_RUNNING;
        else     state_d = ST_STOPPED;
      end
      ST_RUNNING: begin
        if (!run) state_d = ST_STOPPED;
        else      state_d = ST_RUNNING;
      end
      default: state_d = ST_STOPPED;
    endcase
  end

  // Prescaler: counts only while staying in RUNNING, so entering RUNNING restarts it.
  always_comb begin
    cnt_d = CNT_W'(0);
    if ((state_q == ST_RUNNING) && (state_d == ST_RUNNING)) begin
      if (cnt_q == DIV_M1) cnt_d = CNT_W'(0);
      else                 cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = CNT_W'(0);
    end
    tick_d = (state_d == ST_RUNNING) && (cnt_d == DIV_M1);
  end

  // Advance detection, plaintext counter and key latch.
  always_comb begin
    adv_s    = (state_q == ST_RUNNING) ? tick_q : (step && !step_q);
    key_ok_s = key_load && ({1'b0, key_in} < N_W);
    plain_d  = plain_q;
    key_d    = key_q;
    err_d    = err_q;
    if (adv_s) begin
      if (dir) plain_d = (plain_q == WIDTH'(0)) ? N_M1 : (plain_q - WIDTH'(1));
      else     plain_d = (plain_q == N_M1) ? WIDTH'(0) : (plain_q + WIDTH'(1));
    end else begin
      plain_d = plain_q;
    end
    if (key_ok_s) begin
      key_d = key_in;
      err_d = 1'b0;
    end else if (key_load) begin
      err_d = 1'b1;
    end else begin
      err_d = err_q;
    end
    step_d  = step;
    upd_d   = adv_s || key_ok_s;
    enc_d   = encrypt;
    // cipher_q updates next edge from plain/key that changed at the last edge,
    // or from an encrypt value differing from last cycle's.
    valid_d = upd_q || (encrypt != enc_q);
  end

  // Modular add/subtract by a single compare-and-correct step.
  always_comb begin
    sum_s    = {1'b0, plain_q} + {1'b0, key_q};
    cipher_d = cipher_q;
    if (encrypt) begin
      if (sum_s >= N_W) cipher_d = WIDTH'(sum_s - N_W);
      else              cipher_d = WIDTH'(sum_s);
    end else begin
      if (plain_q >= key_q) cipher_d = plain_q - key_q;
      else                  cipher_d = WIDTH'({1'b0, plain_q} + N_W - {1'b0, key_q});
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge CLOCK_50) begin
    if (rst) begin
      state_q  <= ST_STOPPED;
      cnt_q    <= CNT_W'(0);
      tick_q   <= 1'b0;
      step_q   <= 1'b0;
      plain_q  <= WIDTH'(0);
      key_q    <= WIDTH'(0);
      err_q    <= 1'b0;
      cipher_q <= WIDTH'(0);
      valid_q  <= 1'b0;
      upd_q    <= 1'b0;
      enc_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      tick_q   <= tick_d;
      step_q   <= step_d;
      plain_q  <= plain_d;
      key_q    <= key_d;
      err_q    <= err_d;
      cipher_q <= cipher_d;
      valid_q  <= valid_d;
      upd_q    <= upd_d;
      enc_q    <= enc_d;
    end
  end

  assign plain_out  = plain_q;
  assign key_out    = key_q;
  assign cipher_out = cipher_q;
  assign out_valid  = valid_q;
  assign tick       = tick_q;
  assign key_err    = err_q;

endmodule
